conv3x3_sequencer: RTL and testbench
====================================

# conv3x3_sequencer

Time-multiplexed controller for the 3×3 pixel-kernel datapath. It accepts a stream of nine 9-bit pixels per window over a valid/ready handshake and sequences a single shared multiply-accumulate through the nine kernel taps. It then presents one saturated 20-bit signed result per window. It sits between the pixel source and the result consumer, and replaces nine parallel multipliers with one.

## Interface
- PIX_W, 9: pixel width, unsigned
- COEF_W, 8: kernel coefficient width, signed two's complement
- RES_W, 20: result width, signed
- NTAPS, 9: taps per window
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  4  tap index 0..8
- cfg_data  in  COEF_W  coefficient value
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when valid&ready
- pix_data  in  PIX_W  pixel value
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  RES_W  saturated window sum
- res_ovf  out  1  saturation occurred in this window, qualified by res_valid
- busy  out  1  window in progress (state ≠ IDLE)

## Operation
- Coefficient bank: 9 × COEF_W registers. Reset value is the identity kernel: coef[4]=1, all others 0.
- Coefficient writes:
  - Writes with cfg_we=1 take effect only in IDLE.
  - Writes in ACCUM or OUT are dropped silently.
  - Writes with cfg_addr>8 are dropped.
- FSM states: IDLE, ACCUM, OUT.
  - IDLE: pix_ready=1. A pixel handshake loads acc = product(pix, coef[0]), sets tap=1, clears ovf, and moves to ACCUM.
  - ACCUM: pix_ready=1. Each handshake does acc = sat(acc + product(pix, coef[tap])) and increments tap. The handshake at tap=8 moves to OUT. With no handshake, state, tap and acc hold.
  - OUT: pix_ready=0, res_valid=1. res_data=acc and res_ovf=ovf, both stable until the handshake. res_valid&res_ready returns to IDLE.
- Arithmetic:
  - product = signed({1'b0,pix}) × signed(coef), 18 bits signed.
  - Sum computed at 21 bits, then saturated to RES_W: values above +524287 clamp to +524287, values below −524288 clamp to −524288. Clamping sets the sticky ovf for the window.
  - Saturation is applied per accumulation step.
- Reset (asynchronous, rst_n=0, any time including mid-window):
  - state=IDLE, tap=0, acc=0, ovf=0.
  - Coefficients return to the identity kernel.
  - Outputs: pix_ready=0 while rst_n=0, and 1 from the first edge after release; res_valid=0, res_data=0, res_ovf=0, busy=0.
  - A partial window is discarded.

## Timing
- One pixel per cycle maximum; pix_ready is combinational from state only, never from pix_valid.
- Latency: res_valid rises on the edge that accepts pixel 9.
- Result hold: OUT lasts 1 cycle if res_ready=1, otherwise until res_ready.
- Minimum window period: 10 cycles (9 accept + 1 OUT). The next window's first pixel is accepted no earlier than the cycle after the OUT handshake.
- pix_valid may deassert between pixels; gaps stall the window with no timeout.
- A coefficient write and a first pixel in the same IDLE cycle: the write commits, and the pixel uses the old coef[0].
- busy=1 in ACCUM and OUT.

## Structure
- Shared package conv_pkg holds:
  - PIX_W, COEF_W, RES_W, NTAPS constants.
  - RES_MAX/RES_MIN saturation limits.
  - State enum (IDLE/ACCUM/OUT).
- Sub-module mac_sat: combinational product plus saturating add, with outputs sum and clamp flag. The FSM, tap counter and coefficient bank live in conv3x3_sequencer.

## Test plan
- Identity kernel after reset, pixels 0..8 with pixel 4 = 301 → res_data=301, res_ovf=0, res_valid on the cycle after pixel 9.
- All coef=127 via cfg writes, nine pixels of 511 → unclamped sum 584073, res_data=524287, res_ovf=1.
- All coef=−128, nine pixels of 511 → res_data=−524288, res_ovf=1. The next window uses all coef=1 and pixels 1..9, giving res_data=45 and res_ovf=0.
- Backpressure: hold res_ready=0 for 5 cycles in OUT → res_data stable, pix_ready=0, busy=1. Releasing res_ready gives IDLE the next cycle.
- Write cfg_addr=0, data=5 during ACCUM → ignored, the current window is unchanged. The same write in IDLE changes the next window's result accordingly.
- Assert rst_n=0 after 4 pixels → outputs go to reset values immediately. A full window afterwards yields the identity result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, saturation limits and FSM encoding for the 3x3 kernel sequencer.
package conv_pkg;

  localparam int PIX_W  = 9;
  localparam int COEF_W = 8;
  localparam int RES_W  = 20;
  localparam int NTAPS  = 9;

  // Signed product of a zero-extended pixel and a signed coefficient.
  localparam int PROD_W = PIX_W + 1 + COEF_W;

  localparam logic signed [RES_W-1:0] RES_MAX = 20'sh7FFFF;  // +524287
  localparam logic signed [RES_W-1:0] RES_MIN = 20'sh80000;  // -524288

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/mac_sat.sv
// Combinational multiply plus saturating accumulate for one kernel tap.
module mac_sat
  import conv_pkg::*;
(
  input  logic signed [RES_W-1:0]  acc_in,
  input  logic        [PIX_W-1:0]  pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [RES_W-1:0]  sum,
  output logic                     clamp
);

  logic signed [PROD_W-1:0] prod;
  logic        [RES_W:0]    wide;

  // Product, one-guard-bit sum, and clamp to the RES_W range when the guard bit disagrees.
  always_comb begin
    prod  = $signed({1'b0, pix}) * coef;
    wide  = {acc_in[RES_W-1], acc_in} + {{(RES_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    clamp = (wide[RES_W] != wide[RES_W-1]);
    if (clamp) begin
      sum = wide[RES_W] ? RES_MIN : RES_MAX;
    end else begin
      sum = wide[RES_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_sequencer.sv
// Time-multiplexed 3x3 kernel controller: one shared MAC stepped through nine taps per window.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// Ready never depends on valid. Once valid is raised, data is held stable until the transfer.
module conv3x3_sequencer
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [COEF_W-1:0]        cfg_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [RES_W-1:0]  res_data,
  output logic                     res_ovf,
  output logic                     busy,
  output state_t                   dbg_state
);

  state_t                   state_q, state_d;
  logic [3:0]               tap_q, tap_d;
  logic signed [RES_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     rdy_en_q, rdy_en_d;
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];

  logic                     pix_hs;
  logic signed [RES_W-1:0]  mac_acc_in;
  logic signed [RES_W-1:0]  mac_sum;
  logic                     mac_clamp;

  // The first tap of a window starts from zero, so the product is loaded directly.
  assign mac_acc_in = (state_q == ACCUM) ? acc_q : '0;

  mac_sat u_mac (
    .acc_in (mac_acc_in),
    .pix    (pix_data),
    .coef   (coef_q[tap_q]),
    .sum    (mac_sum),
    .clamp  (mac_clamp)
  );

  // Ready is held low through reset and comes up on the first edge after release.
  assign pix_ready = rdy_en_q && (state_q != OUT);
  assign pix_hs    = pix_valid && pix_ready;
  assign res_valid = (state_q == OUT);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_ovf   = res_valid ? ovf_q : 1'b0;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Coefficient bank update: only in IDLE and only for valid tap indices.
  always_comb begin
    coef_d = coef_q;
    if (cfg_we && (state_q == IDLE) && (cfg_addr < 4'(NTAPS))) begin
      coef_d[cfg_addr] = cfg_data;
    end
  end

  // Next-state logic: window start, per-tap accumulation, result hold.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    rdy_en_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (pix_hs) begin
          acc_d   = mac_sum;
          ovf_d   = 1'b0;
          tap_d   = 4'd1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pix_hs) begin
          acc_d = mac_sum;
          ovf_d = ovf_q | mac_clamp;
          if (tap_q == 4'(NTAPS - 1)) begin
            tap_d   = 4'd0;
            state_d = OUT;
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tap_d   = 4'd0;
      end
    endcase
  end

  // State, datapath and coefficient registers; reset restores the identity kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tap_q    <= 4'd0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= (i == NTAPS / 2) ? COEF_W'(1) : '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= rdy_en_d;
      coef_q   <= coef_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Self-checking bench for conv3x3_sequencer: directed scenarios plus randomized windows.
module tb_conv3x3_sequencer;
  import conv_pkg::*;

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [3:0]              cfg_addr = '0;
  logic [COEF_W-1:0]       cfg_data = '0;
  logic                    pix_valid = 1'b0;
  logic                    pix_ready;
  logic [PIX_W-1:0]        pix_data = '0;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic signed [RES_W-1:0] res_data;
  logic                    res_ovf;
  logic                    busy;
  state_t                  dbg_state;

  always #5 clk = ~clk;

  conv3x3_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int mcoef [9];
  logic [RES_W:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [RES_W:0] model_window(input int c [9], input int p [9]);
    longint acc;
    bit     ovf;
    ovf = 1'b0;
    acc = longint'(p[0]) * c[0];
    for (int t = 1; t < 9; t++) begin
      acc = acc + longint'(p[t]) * c[t];
      if (acc > 524287) begin
        acc = 524287;
        ovf = 1'b1;
      end else if (acc < -524288) begin
        acc = -524288;
        ovf = 1'b1;
      end
    end
    return {ovf, acc[RES_W-1:0]};
  endfunction

  task automatic reset_mirror();
    for (int i = 0; i < 9; i++) mcoef[i] = 0;
    mcoef[4] = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input bit commit);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (commit && a < 4'd9) mcoef[a] = int'($signed(d));
  endtask

  task automatic send_pixel(input int v, input int max_gap);
    int cnt;
    pix_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = v[PIX_W-1:0];
    cnt = 0;
    while (!pix_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt >= 40) begin
      failures++;
      $display("FAIL pix_accept_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, cnt);
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic send_window(input int p [9], input int max_gap);
    for (int i = 0; i < 9; i++) send_pixel(p[i], max_gap);
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency: res_valid=%0b on cycle after pixel 9, required 1", res_valid);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic get_result(input string name, input int delay);
    int cnt;
    logic [RES_W:0] exp_v;
    logic [RES_W:0] got_v;
    res_ready = 1'b0;
    repeat (delay) @(negedge clk);
    cnt = 0;
    while (!res_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    res_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_queue: expected queue empty, required one entry", name);
      exp_v = '0;
    end else begin
      exp_v = exp_q.pop_front();
    end
    got_v = {res_ovf, res_data};
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got ovf=%0b data=%0d, required ovf=%0b data=%0d",
               name, got_v[RES_W], $signed(got_v[RES_W-1:0]), exp_v[RES_W], $signed(exp_v[RES_W-1:0]));
    end
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_return_idle: res_valid=%0b busy=%0b pix_ready=%0b, required 0 0 1",
               name, res_valid, busy, pix_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    reset_mirror();
    #1;
    checks++;
    if (pix_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || res_ovf !== 1'b0 ||
        busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b data=%0d ovf=%0b busy=%0b, required all 0",
               pix_ready, res_valid, res_data, res_ovf, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: pix_ready=%0b, required 1", pix_ready);
    end
  endtask

  task automatic test_identity();
    int p [9] = '{0, 1, 2, 3, 301, 5, 6, 7, 8};
    send_window(p, 0);
    exp_q.push_back({1'b0, 20'd301});
    get_result("identity", 0);
  endtask

  task automatic test_sat_pos();
    int p [9] = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'h7F, 1'b1);
    send_window(p, 1);
    exp_q.push_back({1'b1, 20'h7FFFF});
    get_result("sat_pos", 0);
  endtask

  task automatic test_sat_neg_then_ones();
    int p [9] = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    int q [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'h80, 1'b1);
    send_window(p, 1);
    exp_q.push_back({1'b1, 20'h80000});
    get_result("sat_neg", 1);
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'h01, 1'b1);
    send_window(q, 0);
    exp_q.push_back({1'b0, 20'd45});
    get_result("ones_after_sat", 0);
  endtask

  task automatic test_backpressure();
    int p [9] = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    res_ready = 1'b0;
    send_window(p, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 20'sd126 || pix_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b data=%0d ready=%0b busy=%0b, required 1 126 0 1",
                 i, res_valid, res_data, pix_ready, busy);
      end
      @(negedge clk);
    end
    exp_q.push_back({1'b0, 20'd126});
    get_result("backpressure", 0);
  endtask

  task automatic test_cfg_during_accum();
    int q [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    for (int i = 0; i < 4; i++) send_pixel(q[i], 0);
    cfg_write(4'd0, 8'd5, 1'b0);
    for (int i = 4; i < 9; i++) send_pixel(q[i], 0);
    exp_q.push_back({1'b0, 20'd45});
    get_result("cfg_in_accum", 0);
    cfg_write(4'd0, 8'd5, 1'b1);
    send_window(q, 0);
    exp_q.push_back({1'b0, 20'd49});
    get_result("cfg_in_idle", 0);
    // Coefficient write and first pixel in the same IDLE cycle: pixel sees old coef[0]=5.
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 4'd0;
    cfg_data  = 8'd3;
    pix_valid = 1'b1;
    pix_data  = 9'd1;
    @(negedge clk);
    cfg_we    = 1'b0;
    pix_valid = 1'b0;
    mcoef[0]  = 3;
    for (int i = 1; i < 9; i++) send_pixel(q[i], 0);
    exp_q.push_back({1'b0, 20'd49});
    get_result("cfg_same_cycle", 0);
    send_window(q, 0);
    exp_q.push_back({1'b0, 20'd47});
    get_result("cfg_same_cycle_next", 0);
  endtask

  task automatic test_reset_mid_window();
    int p [9];
    for (int i = 0; i < 4; i++) send_pixel(int'($urandom_range(0, 511)), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 || res_ovf !== 1'b0 ||
        busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL mid_reset_outputs: ready=%0b valid=%0b data=%0d ovf=%0b busy=%0b, required all 0",
               pix_ready, res_valid, res_data, res_ovf, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_mirror();
    for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(0, 511));
    send_window(p, 1);
    exp_q.push_back({1'b0, 11'd0, p[4][8:0]});
    get_result("identity_after_reset", 0);
  endtask

  task automatic test_random_windows();
    int p [9];
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'($urandom_range(0, 255)), 1'b1);
      cfg_write(4'($urandom_range(9, 15)), 8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(0, 511));
      send_window(p, 2);
      exp_q.push_back(model_window(mcoef, p));
      get_result($sformatf("random_w%0d", w), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    int p [9];
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 8'($urandom_range(0, 255)), 1'b1);
    res_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(0, 511));
      exp_q.push_back(model_window(mcoef, p));
      for (int i = 0; i < 9; i++) send_pixel(p[i], 0);
      checks++;
      if ({res_ovf, res_data} !== exp_q[0] || res_valid !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back_w%0d: valid=%0b ovf=%0b data=%0d, required 1 %0b %0d",
                 w, res_valid, res_ovf, res_data, exp_q[0][RES_W], $signed(exp_q[0][RES_W-1:0]));
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_identity();
    test_sat_pos();
    test_sat_neg_then_ones();
    test_backpressure();
    test_cfg_during_accum();
    test_reset_mid_window();
    test_random_windows();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
